// File: rtl/mem_stage.sv
// MIPS memory stage: EXE/MEM register, word-organised data memory and MEM/WB register.
// Exports the EXE/MEM fields for forwarding/hazard logic and a sticky illegal-access flag.
module mem_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 64,
  parameter int BASE_ADDR  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  WB_EN_in,
  input  logic                  MEM_R_EN_in,
  input  logic                  MEM_W_EN_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [DATA_W-1:0]     ALU_res_in,
  input  logic [DATA_W-1:0]     ST_value_in,
  output logic [DATA_W-1:0]     ALU_res_MEM,
  output logic [REG_ADDR_W-1:0] dest_MEM,
  output logic                  WB_EN_MEM,
  output logic                  MEM_R_EN_MEM,
  output logic                  WB_EN_out,
  output logic                  MEM_R_EN_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [DATA_W-1:0]     ALU_res_out,
  output logic [DATA_W-1:0]     mem_data_out,
  output logic                  mem_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // EXE/MEM register
  logic                  exWbEn_q, exWbEn_d;
  logic                  exREn_q, exREn_d;
  logic                  exWEn_q, exWEn_d;
  logic [REG_ADDR_W-1:0] exDest_q, exDest_d;
  logic [DATA_W-1:0]     exAluRes_q, exAluRes_d;
  logic [DATA_W-1:0]     exStValue_q, exStValue_d;

  // MEM/WB register
  logic                  wbWbEn_q, wbWbEn_d;
  logic                  wbREn_q, wbREn_d;
  logic [REG_ADDR_W-1:0] wbDest_q, wbDest_d;
  logic [DATA_W-1:0]     wbAluRes_q, wbAluRes_d;
  logic [DATA_W-1:0]     wbMemData_q, wbMemData_d;

  logic                  err_q, err_d;

  logic [DATA_W-1:0]     mem_q [DEPTH];

  logic [DATA_W-1:0]     offset;
  logic [IDX_W-1:0]      wordIdx;
  logic                  legal;
  logic                  accessErr;
  logic                  memWrite;
  logic [DATA_W-1:0]     readData;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
  always_comb begin
    offset    = exAluRes_q - DATA_W'(BASE_ADDR);
    wordIdx   = offset[IDX_W+1:2];
    legal     = (offset[1:0] == 2'b00) && ((offset >> 2) < DATA_W'(DEPTH));
    accessErr = (exREn_q || exWEn_q) && !legal;
    memWrite  = exWEn_q && !freeze && legal;
    readData  = '0;
    if (exREn_q && !exWEn_q && legal) begin
      readData = mem_q[wordIdx];
    end
  end

  always_comb begin
    exWbEn_d    = exWbEn_q;
    exREn_d     = exREn_q;
    exWEn_d     = exWEn_q;
    exDest_d    = exDest_q;
    exAluRes_d  = exAluRes_q;
    exStValue_d = exStValue_q;
    if (!freeze) begin
      if (flush) begin
        exWbEn_d    = 1'b0;
        exREn_d     = 1'b0;
        exWEn_d     = 1'b0;
        exDest_d    = '0;
        exAluRes_d  = '0;
        exStValue_d = '0;
      end else begin
        exWbEn_d    = WB_EN_in;
        exREn_d     = MEM_R_EN_in;
        exWEn_d     = MEM_W_EN_in;
        exDest_d    = dest_in;
        exAluRes_d  = ALU_res_in;
        exStValue_d = ST_value_in;
      end
    end
  end

  always_comb begin
    wbWbEn_d    = wbWbEn_q;
    wbREn_d     = wbREn_q;
    wbDest_d    = wbDest_q;
    wbAluRes_d  = wbAluRes_q;
    wbMemData_d = wbMemData_q;
    err_d       = err_q;
    if (!freeze) begin
      wbWbEn_d    = exWbEn_q;
      wbREn_d     = exREn_q;
      wbDest_d    = exDest_q;
      wbAluRes_d  = exAluRes_q;
      wbMemData_d = readData;
      err_d       = err_q | accessErr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exWbEn_q    <= 1'b0;
      exREn_q     <= 1'b0;
      exWEn_q     <= 1'b0;
      exDest_q    <= '0;
      exAluRes_q  <= '0;
      exStValue_q <= '0;
      wbWbEn_q    <= 1'b0;
      wbREn_q     <= 1'b0;
      wbDest_q    <= '0;
      wbAluRes_q  <= '0;
      wbMemData_q <= '0;
      err_q       <= 1'b0;
    end else begin
      exWbEn_q    <= exWbEn_d;
      exREn_q     <= exREn_d;
      exWEn_q     <= exWEn_d;
      exDest_q    <= exDest_d;
      exAluRes_q  <= exAluRes_d;
      exStValue_q <= exStValue_d;
      wbWbEn_q    <= wbWbEn_d;
      wbREn_q     <= wbREn_d;
      wbDest_q    <= wbDest_d;
      wbAluRes_q  <= wbAluRes_d;
      wbMemData_q <= wbMemData_d;
      err_q       <= err_d;
    end
  end

  // A frozen store stays in EXE/MEM, so it lands exactly once on the first unfrozen edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (memWrite) begin
      mem_q[wordIdx] <= exStValue_q;
    end
  end

  assign ALU_res_MEM  = exAluRes_q;
  assign dest_MEM     = exDest_q;
  assign WB_EN_MEM    = exWbEn_q;
  assign MEM_R_EN_MEM = exREn_q;
  assign WB_EN_out    = wbWbEn_q;
  assign MEM_R_EN_out = wbREn_q;
  assign dest_out     = wbDest_q;
  assign ALU_res_out  = wbAluRes_q;
  assign mem_data_out = wbMemData_q;
  assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a program-order memory model predicts each instruction's
// EXE/MEM and MEM/WB contents; a monitor compares them after every clock edge.
module tb_mem_stage;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DEPTH      = 64;
  localparam int BASE_ADDR  = 1024;

  typedef struct {
    logic        wb;
    logic        rEn;
    logic        wEn;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] st;
  } instr_t;

  typedef struct {
    logic        wb;
    logic        rEn;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] data;
    logic        err;
  } expect_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic freeze = 1'b0, flush = 1'b0;
  logic wbEnIn = 1'b0, rEnIn = 1'b0, wEnIn = 1'b0;
  logic [REG_ADDR_W-1:0] destIn = '0;
  logic [DATA_W-1:0] aluResIn = '0, stValueIn = '0;

  logic [DATA_W-1:0]     aluResMem, aluResOut, memDataOut;
  logic [REG_ADDR_W-1:0] destMem, destOut;
  logic                  wbEnMem, rEnMem, wbEnOut, rEnOut, memErr;

  expect_t exQ[$];
  expect_t wbQ[$];
  expect_t lastEx, lastWb;
  logic [31:0] modelMem [DEPTH];
  logic modelErr;

  int checkCount = 0;
  int passCount  = 0;

  mem_stage #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .WB_EN_in(wbEnIn), .MEM_R_EN_in(rEnIn), .MEM_W_EN_in(wEnIn),
    .dest_in(destIn), .ALU_res_in(aluResIn), .ST_value_in(stValueIn),
    .ALU_res_MEM(aluResMem), .dest_MEM(destMem), .WB_EN_MEM(wbEnMem),
    .MEM_R_EN_MEM(rEnMem), .WB_EN_out(wbEnOut), .MEM_R_EN_out(rEnOut),
    .dest_out(destOut), .ALU_res_out(aluResOut), .mem_data_out(memDataOut),
    .mem_err(memErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Instructions are modelled in program order at the moment they enter EXE/MEM.
  function automatic void modelIssue(input instr_t ins);
    logic [31:0] off;
    bit legal;
    expect_t e;
    off   = ins.alu - 32'(BASE_ADDR);
    legal = (off % 4 == 0) && (off / 4 < DEPTH);
    e.wb = ins.wb; e.rEn = ins.rEn; e.dest = ins.dest; e.alu = ins.alu; e.data = '0;
    if (ins.wEn) begin
      if (legal) modelMem[off / 4] = ins.st;
    end else if (ins.rEn && legal) begin
      e.data = modelMem[off / 4];
    end
    if ((ins.rEn || ins.wEn) && !legal) modelErr = 1'b1;
    e.err = modelErr;
    exQ.push_back(e);
    wbQ.push_back(e);
  endfunction

  function automatic void resetModel();
    expect_t z;
    z = '{wb: 1'b0, rEn: 1'b0, dest: '0, alu: '0, data: '0, err: 1'b0};
    for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
    modelErr = 1'b0;
    exQ.delete();
    wbQ.delete();
    wbQ.push_back(z);
    lastEx = z;
    lastWb = z;
  endfunction

  task automatic applyStimulus(input logic wb, input logic r, input logic w, input logic [4:0] dest,
                               input logic [31:0] alu, input logic [31:0] st,
                               input logic frz, input logic fl);
    instr_t ins;
    @(negedge clk);
    wbEnIn = wb; rEnIn = r; wEnIn = w; destIn = dest;
    aluResIn = alu; stValueIn = st; freeze = frz; flush = fl;
    if (!frz) begin
      if (fl) ins = '{wb: 1'b0, rEn: 1'b0, wEn: 1'b0, dest: '0, alu: '0, st: '0};
      else    ins = '{wb: wb, rEn: r, wEn: w, dest: dest, alu: alu, st: st};
      modelIssue(ins);
    end
  endtask

  task automatic doReset();
    instr_t bubble;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst ALU_res_MEM",  aluResMem,  '0);
    checkOutput("rst dest_MEM",     32'(destMem), '0);
    checkOutput("rst WB_EN_MEM",    32'(wbEnMem), '0);
    checkOutput("rst MEM_R_EN_MEM", 32'(rEnMem), '0);
    checkOutput("rst WB_EN_out",    32'(wbEnOut), '0);
    checkOutput("rst MEM_R_EN_out", 32'(rEnOut), '0);
    checkOutput("rst dest_out",     32'(destOut), '0);
    checkOutput("rst ALU_res_out",  aluResOut,  '0);
    checkOutput("rst mem_data_out", memDataOut, '0);
    checkOutput("rst mem_err",      32'(memErr), '0);
    @(negedge clk);
    wbEnIn = 0; rEnIn = 0; wEnIn = 0; destIn = '0; aluResIn = '0; stValueIn = '0;
    freeze = 0; flush = 0;
    resetModel();
    rst = 1'b1;
    bubble = '{wb: 1'b0, rEn: 1'b0, wEn: 1'b0, dest: '0, alu: '0, st: '0};
    modelIssue(bubble);
  endtask

  // Monitor: every unfrozen edge presents a new EXE/MEM and MEM/WB pair; frozen edges must hold.
  always @(posedge clk) begin
    logic sRst, sFrz;
    sRst = rst;
    sFrz = freeze;
    #1;
    if (sRst && rst) begin
      if (!sFrz) begin
        if (exQ.size() == 0 || wbQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL scoreboard: got empty queue, expected a pending entry at %0t", $time);
        end else begin
          lastEx = exQ.pop_front();
          lastWb = wbQ.pop_front();
        end
      end
      checkOutput("ALU_res_MEM",  aluResMem,     lastEx.alu);
      checkOutput("dest_MEM",     32'(destMem),  32'(lastEx.dest));
      checkOutput("WB_EN_MEM",    32'(wbEnMem),  32'(lastEx.wb));
      checkOutput("MEM_R_EN_MEM", 32'(rEnMem),   32'(lastEx.rEn));
      checkOutput("WB_EN_out",    32'(wbEnOut),  32'(lastWb.wb));
      checkOutput("MEM_R_EN_out", 32'(rEnOut),   32'(lastWb.rEn));
      checkOutput("dest_out",     32'(destOut),  32'(lastWb.dest));
      checkOutput("ALU_res_out",  aluResOut,     lastWb.alu);
      checkOutput("mem_data_out", memDataOut,    lastWb.data);
      checkOutput("mem_err",      32'(memErr),   32'(lastWb.err));
    end
  end

  initial begin
    logic [31:0] addr;
    logic r, w, frz, fl;
    resetModel();
    doReset();

    // Store then load of the same word.
    applyStimulus(0, 0, 1, 5'd0, 32'd1032, 32'hDEADBEEF, 0, 0);
    applyStimulus(1, 1, 0, 5'd5, 32'd1032, 32'h0, 0, 0);
    // Forwarding path and word 0 initially clear.
    applyStimulus(1, 1, 0, 5'd9, 32'd1024, 32'h0, 0, 0);
    applyStimulus(1, 0, 0, 5'd3, 32'h1234, 32'h0, 0, 0);
    // Store to word 0 held off by freeze, then accepted.
    repeat (3) applyStimulus(0, 0, 1, 5'd0, 32'd1024, 32'h22222222, 1, 0);
    applyStimulus(0, 0, 1, 5'd0, 32'd1024, 32'h22222222, 0, 0);
    applyStimulus(1, 1, 0, 5'd4, 32'd1024, 32'h0, 0, 0);
    // Flushed store must not reach word 1; freeze beats flush.
    applyStimulus(0, 0, 1, 5'd0, 32'd1028, 32'h55AA55AA, 0, 1);
    applyStimulus(0, 0, 1, 5'd0, 32'd1028, 32'h66666666, 1, 1);
    applyStimulus(1, 1, 0, 5'd7, 32'd1028, 32'h0, 0, 0);
    // Illegal accesses: misaligned, past the end, below the base.
    applyStimulus(1, 1, 0, 5'd8, 32'd1026, 32'h0, 0, 0);
    applyStimulus(0, 0, 1, 5'd0, 32'(BASE_ADDR + 4 * DEPTH), 32'hBADBAD00, 0, 0);
    applyStimulus(1, 1, 0, 5'd9, 32'd1020, 32'h0, 0, 0);
    applyStimulus(1, 1, 0, 5'd10, 32'(BASE_ADDR + 4 * (DEPTH - 1)), 32'h0, 0, 0);
    applyStimulus(1, 1, 0, 5'd11, 32'd1024, 32'h0, 0, 0);
    applyStimulus(1, 1, 0, 5'd12, 32'd1032, 32'h0, 0, 0);
    applyStimulus(0, 1, 1, 5'd13, 32'd1036, 32'h13579BDF, 0, 0);
    applyStimulus(1, 1, 0, 5'd14, 32'd1036, 32'h0, 0, 0);

    // Reset with a store pending in EXE/MEM.
    applyStimulus(0, 0, 1, 5'd0, 32'd1024, 32'hCAFEF00D, 0, 0);
    doReset();
    applyStimulus(1, 1, 0, 5'd2, 32'd1024, 32'h0, 0, 0);
    applyStimulus(1, 1, 0, 5'd2, 32'd1032, 32'h0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       addr = 32'(BASE_ADDR) - 32'(4 * $urandom_range(1, 4));
        1:       addr = 32'(BASE_ADDR + 4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
        2:       addr = 32'(BASE_ADDR) + 32'($urandom_range(0, 4 * DEPTH - 1));
        default: addr = 32'(BASE_ADDR) + 32'(4 * $urandom_range(0, 7));
      endcase
      r   = ($urandom_range(0, 2) == 0);
      w   = ($urandom_range(0, 2) == 0);
      frz = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      applyStimulus(1'($urandom_range(0, 1)), r, w, 5'($urandom_range(0, 31)),
                    addr, $urandom, frz, fl);
    end

    applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0);
    applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
